// File: rtl/aes_pkg.sv
// Shared AES types and helpers for the decryption round datapath.
package aes_pkg;

  localparam int unsigned AES_NB_BYTES = 16;

  typedef logic [7:0]   aes_byte_t;
  typedef logic [127:0] aes_state_t;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_BUSY,
    ST_DONE
  } isb_state_e;

  // Byte 0 is the most significant byte of the state (FIPS-197 order).
  function automatic aes_byte_t aes_get_byte(input aes_state_t s, input int unsigned k);
    return s[127 - 8*k -: 8];
  endfunction

endpackage

// File: rtl/aes_inv_sbox.sv
// Combinational FIPS-197 inverse S-box lookup, one byte in, one byte out.
module aes_inv_sbox (
  input  logic [7:0] i_byte,
  output logic [7:0] o_byte
);
  import aes_pkg::*;

  // Entry n of the table sits at index n; rows are 16 consecutive entries.
  localparam logic [0:255][7:0] INV_SBOX = {
    128'h52096ad53036a538bf40a39e81f3d7fb,
    128'h7ce339829b2fff87348e4344c4dee9cb,
    128'h547b9432a6c2233dee4c950b42fac34e,
    128'h082ea16628d924b2765ba2496d8bd125,
    128'h72f8f66486689816d4a45ccc5d65b692,
    128'h6c704850fdedb9da5e154657a78d9d84,
    128'h90d8ab008cbcd30af7e45805b8b34506,
    128'hd02c1e8fca3f0f02c1afbd0301138a6b,
    128'h3a9111414f67dcea97f2cfcef0b4e673,
    128'h96ac7422e7ad3585e2f937e81c75df6e,
    128'h47f11a711d29c5896fb7620eaa18be1b,
    128'hfc563e4bc6d279209adbc0fe78cd5af4,
    128'h1fdda8338807c731b11210592780ec5f,
    128'h60517fa919b54a0d2de57a9f93c99cef,
    128'ha0e03b4dae2af5b0c8ebbb3c83539961,
    128'h172b047eba77d626e169146355210c7d
  };

  aes_byte_t w_byte;

  always_comb begin
    w_byte = INV_SBOX[i_byte];
  end

  assign o_byte = w_byte;

endmodule

// File: rtl/inv_sub_bytes_iter.sv
// Iterative InvSubBytes: LANES inverse S-box lookups per cycle over a
// captured 128-bit state, result handed downstream over valid/ready.
module inv_sub_bytes_iter #(
  parameter int unsigned LANES = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [127:0] in_data,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [127:0] out_data,
  output logic         busy
);
  import aes_pkg::*;

  localparam int unsigned NSTEP = AES_NB_BYTES / LANES;
  localparam int unsigned CW    = (NSTEP > 1) ? $clog2(NSTEP) : 1;

  if (!(LANES == 1 || LANES == 2 || LANES == 4 || LANES == 8 || LANES == 16)) begin : g_bad_lanes
    $error("inv_sub_bytes_iter: LANES must be 1, 2, 4, 8 or 16");
  end

  isb_state_e    r_state;
  logic [CW-1:0] r_cnt;
  aes_state_t    r_src;
  aes_state_t    r_res;

  aes_byte_t     w_lane_in  [LANES];
  aes_byte_t     w_lane_out [LANES];
  aes_state_t    w_res_next;
  logic          w_last;

  for (genvar g = 0; g < LANES; g++) begin : g_lane
    assign w_lane_in[g] = aes_get_byte(r_src, 32'(r_cnt) * LANES + 32'(g));

    aes_inv_sbox u_sbox (
      .i_byte (w_lane_in[g]),
      .o_byte (w_lane_out[g])
    );
  end

  // Only the LANES bytes selected by r_cnt change; the rest of r_res holds.
  always_comb begin
    w_res_next = r_res;
    for (int unsigned j = 0; j < LANES; j++) begin
      w_res_next[127 - 8*(32'(r_cnt) * LANES + j) -: 8] = w_lane_out[j];
    end
  end

  assign w_last = (r_cnt == CW'(NSTEP - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
      r_cnt   <= '0;
      r_src   <= '0;
      r_res   <= '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (in_valid) begin
            r_src   <= in_data;
            r_cnt   <= '0;
            r_state <= ST_BUSY;
          end
        end
        ST_BUSY: begin
          r_res <= w_res_next;
          if (w_last) begin
            r_cnt   <= '0;
            r_state <= ST_DONE;
          end else begin
            r_cnt <= r_cnt + CW'(1);
          end
        end
        ST_DONE: begin
          if (out_ready) begin
            r_state <= ST_IDLE;
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign in_ready  = (r_state == ST_IDLE);
  assign out_valid = (r_state == ST_DONE);
  assign busy      = (r_state != ST_IDLE);
  assign out_data  = r_res;

endmodule

// File: tb/tb_inv_sub_bytes_iter.sv
// Self-checking bench for inv_sub_bytes_iter: table vectors, full byte sweep,
// handshake corner cases and a LANES sweep against an algorithmic reference.
module tb_inv_sub_bytes_iter;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         in_valid;
  logic         in_ready;
  logic [127:0] in_data;
  logic         out_valid;
  logic         out_ready;
  logic [127:0] out_data;
  logic         busy;

  logic         sw_valid;
  logic         sw_out_ready;
  logic [3:0]   sw_in_ready;
  logic [3:0]   sw_out_valid;
  logic [3:0]   sw_busy;
  logic [127:0] sw_out_data [4];

  int checks = 0;
  int errors = 0;

  logic [7:0]   ref_inv [256];
  logic [127:0] sb_q [$];

  localparam logic [127:0] BASIC_IN  = 128'h637c777bf26b6fc53001672bfed7ab76;
  localparam logic [127:0] BASIC_EXP = 128'h000102030405060708090a0b0c0d0e0f;

  always #5 clk = ~clk;

  inv_sub_bytes_iter #(.LANES(4)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .busy      (busy)
  );

  for (genvar g = 0; g < 4; g++) begin : g_sw
    localparam int unsigned SWL = (g == 0) ? 1 : (g == 1) ? 2 : (g == 2) ? 8 : 16;
    inv_sub_bytes_iter #(.LANES(SWL)) u_dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (sw_valid),
      .in_ready  (sw_in_ready[g]),
      .in_data   (in_data),
      .out_valid (sw_out_valid[g]),
      .out_ready (sw_out_ready),
      .out_data  (sw_out_data[g]),
      .busy      (sw_busy[g])
    );
  end

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p, x, y;
    p = 8'h00; x = a; y = b;
    for (int i = 0; i < 8; i++) begin
      if (y[0]) p = p ^ x;
      x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
      y = y >> 1;
    end
    return p;
  endfunction

  function automatic logic [7:0] rotl8(input logic [7:0] b, input int n);
    return (b << n) | (b >> (8 - n));
  endfunction

  // Forward S-box from GF(2^8) inverse + affine map, then inverted.
  task automatic build_model();
    logic [7:0] inv, s, xb;
    for (int x = 0; x < 256; x++) begin
      xb  = 8'(x);
      inv = 8'h00;
      for (int y = 1; y < 256; y++) begin
        if (xb != 8'h00 && gmul(xb, 8'(y)) == 8'h01) inv = 8'(y);
      end
      s = inv ^ rotl8(inv, 1) ^ rotl8(inv, 2) ^ rotl8(inv, 3) ^ rotl8(inv, 4) ^ 8'h63;
      ref_inv[s] = xb;
    end
  endtask

  function automatic logic [127:0] model(input logic [127:0] s);
    logic [127:0] r;
    r = '0;
    for (int k = 0; k < 16; k++) r[127 - 8*k -: 8] = ref_inv[s[127 - 8*k -: 8]];
    return r;
  endfunction

  always @(negedge clk) begin
    if (rst_n && out_valid && out_ready) begin
      if (sb_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_output: got %h expected none", out_data);
      end else begin
        chk("scoreboard", out_data, sb_q.pop_front());
      end
    end
  end

  task automatic send(input logic [127:0] d, input logic [127:0] e, input bit push);
    int k;
    k = 0;
    while (!in_ready && k < 50) begin
      @(posedge clk); #1; k++;
    end
    chk("send_ready", in_ready, 1);
    in_valid = 1'b1;
    in_data  = d;
    if (push) sb_q.push_back(e);
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic wait_valid(output int n);
    n = 0;
    while (!out_valid && n < 40) begin
      @(posedge clk); #1; n++;
    end
    chk("out_valid_seen", out_valid, 1);
  endtask

  typedef struct {
    logic [127:0] din;
    logic [127:0] exp;
  } vec_t;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t         vecs [5];
    int           n;
    int           lat [4];
    logic [127:0] dat [4];
    logic [255:0] seen;
    logic [127:0] exp_a, exp_b, exp_c, rnd;
    int           exp_lat [4];

    build_model();
    rst_n = 1'b0; in_valid = 1'b0; in_data = '0; out_ready = 1'b1;
    sw_valid = 1'b0; sw_out_ready = 1'b1;

    rnd = {$urandom, $urandom, $urandom, $urandom};
    vecs[0] = '{BASIC_IN, BASIC_EXP};
    vecs[1] = '{{16{8'h16}}, {16{8'hff}}};
    vecs[2] = '{128'h0, {16{8'h52}}};
    vecs[3] = '{128'h52096ad53036a538bf40a39e81f3d7fb, model(128'h52096ad53036a538bf40a39e81f3d7fb)};
    vecs[4] = '{rnd, model(rnd)};

    #2;
    chk("rst_in_ready", in_ready, 1);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out_data", out_data, 0);
    chk("rst_busy", busy, 0);
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    #1 chk("post_rst_in_ready", in_ready, 1);

    // Basic block with latency and one-cycle out_valid
    send(BASIC_IN, BASIC_EXP, 1'b1);
    wait_valid(n);
    chk("basic_latency", n, 4);
    chk("basic_data", out_data, BASIC_EXP);
    @(posedge clk); #1;
    chk("basic_valid_pulse", out_valid, 0);

    for (int i = 0; i < 5; i++) begin
      send(vecs[i].din, vecs[i].exp, 1'b1);
      wait_valid(n);
      @(posedge clk); #1;
    end

    seen = '0;
    for (int v = 0; v < 256; v++) begin
      send({16{8'(v)}}, model({16{8'(v)}}), 1'b1);
      wait_valid(n);
      seen[out_data[127:120]] = 1'b1;
      @(posedge clk); #1;
    end
    chk("perm_count", $countones(seen), 256);

    // Backpressure with the next block waiting upstream
    exp_a = model(128'h0123456789abcdeffedcba9876543210);
    exp_b = model(128'hdeadbeefcafef00d0badc0de12345678);
    out_ready = 1'b0;
    send(128'h0123456789abcdeffedcba9876543210, exp_a, 1'b1);
    wait_valid(n);
    in_valid = 1'b1;
    in_data  = 128'hdeadbeefcafef00d0badc0de12345678;
    sb_q.push_back(exp_b);
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); #1;
      chk("bp_valid", out_valid, 1);
      chk("bp_data", out_data, exp_a);
      chk("bp_in_ready", in_ready, 0);
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    chk("bp_release_in_ready", in_ready, 1);
    chk("bp_release_valid", out_valid, 0);
    @(posedge clk); #1;
    chk("bp_second_accept", in_ready, 0);
    chk("bp_second_busy", busy, 1);
    in_valid = 1'b0;
    wait_valid(n);
    @(posedge clk); #1;

    // in_valid pulsed during BUSY must be ignored
    exp_c = model(128'h00112233445566778899aabbccddeeff);
    send(128'h00112233445566778899aabbccddeeff, exp_c, 1'b1);
    @(posedge clk); #1;
    in_valid = 1'b1;
    in_data  = '1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    in_data  = '0;
    wait_valid(n);
    chk("ignored_data", out_data, exp_c);
    @(posedge clk); #1;
    for (int i = 0; i < 8; i++) begin
      @(posedge clk); #1;
      chk("ignored_no_extra", out_valid, 0);
    end

    // Asynchronous reset two cycles into a block
    send(BASIC_IN, '0, 1'b0);
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst_n = 1'b0;
    #1;
    chk("midrst_out_valid", out_valid, 0);
    chk("midrst_out_data", out_data, 0);
    chk("midrst_in_ready", in_ready, 1);
    chk("midrst_busy", busy, 0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    send({16{8'h16}}, {16{8'hff}}, 1'b1);
    wait_valid(n);
    chk("midrst_after_latency", n, 4);
    @(posedge clk); #1;

    // LANES sweep: 1, 2, 8, 16
    exp_lat = '{16, 8, 2, 1};
    for (int g = 0; g < 4; g++) begin
      lat[g] = 0;
      dat[g] = '0;
    end
    chk("sweep_idle", sw_in_ready, 4'hf);
    in_data  = BASIC_IN;
    sw_valid = 1'b1;
    @(posedge clk); #1;
    sw_valid = 1'b0;
    for (int c = 1; c <= 24; c++) begin
      @(posedge clk); #1;
      for (int g = 0; g < 4; g++) begin
        if (lat[g] == 0 && sw_out_valid[g]) begin
          lat[g] = c;
          dat[g] = sw_out_data[g];
        end
      end
    end
    for (int g = 0; g < 4; g++) begin
      chk($sformatf("sweep_latency_%0d", g), lat[g], exp_lat[g]);
      chk($sformatf("sweep_data_%0d", g), dat[g], BASIC_EXP);
    end

    chk("scoreboard_empty", sb_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
